// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit between the EX/MEM register and a
// word-addressed data memory. Handles byte/half/word loads with sign or zero
// extension, word stores, and sub-word stores done as read-modify-write.
// All memory strobes come straight from flops so the memory sees clean edges.
// Optional feature: define LSU_RANGE_CHECK_EN to fault on word indices that
// fall outside MEM_WORDS instead of passing them to the memory.
module lsu_mem_stage #(
  parameter int MEM_WORDS = 42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        fault
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_ISSUE = 3'd3;
  localparam logic [2:0] FAULT    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        isStore_q, isStore_d;
  logic [1:0]  size_q, size_d;
  logic        isUnsigned_q, isUnsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] storeData_q, storeData_d;
  logic [4:0]  rd_q, rd_d;
  logic        memWe_q, memWe_d;
  logic        memRe_q, memRe_d;
  logic [31:0] memA_q, memA_d;
  logic [31:0] memWd_q, memWd_d;
  logic        wbValid_q, wbValid_d;
  logic [31:0] wbData_q, wbData_d;
  logic [4:0]  wbRd_q, wbRd_d;
  logic        fault_q, fault_d;

  logic        reqIsWord;
  logic        reqIsHalf;
  logic        misaligned;
  logic        rangeFault;
  logic        reqFault;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadValue;
  logic [31:0] mergedWord;

  // Size code 11 behaves exactly like a word access.
  assign reqIsWord  = req_size[1];
  assign reqIsHalf  = (req_size == 2'b01);
  assign misaligned = (reqIsHalf && req_addr[0]) ||
                      (reqIsWord && (req_addr[1:0] != 2'b00));

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [29:0] MemWordsW = 30'(MEM_WORDS);
  assign rangeFault = (req_addr[31:2] >= MemWordsW);
`else
  assign rangeFault = 1'b0;
`endif

  assign reqFault = misaligned || rangeFault;

  // Upstream must hold its request whenever the unit is not idle.
  assign stall    = (state_q != IDLE);
  assign mem_we   = memWe_q;
  assign mem_re   = memRe_q;
  assign mem_a    = memA_q;
  assign mem_wd   = memWd_q;
  assign wb_valid = wbValid_q;
  assign wb_data  = wbData_q;
  assign wb_rd    = wbRd_q;
  assign fault    = fault_q;

  // Lane extraction for loads and lane replacement for sub-word stores,
  // both working on the word returned by memory in RD_WAIT.
  always_comb begin
    laneByte   = 8'h00;
    laneHalf   = 16'h0000;
    loadValue  = mem_rd;
    mergedWord = mem_rd;
    case (lane_q)
      2'd0:    laneByte = mem_rd[7:0];
      2'd1:    laneByte = mem_rd[15:8];
      2'd2:    laneByte = mem_rd[23:16];
      default: laneByte = mem_rd[31:24];
    endcase
    laneHalf = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      2'b00: begin
        loadValue = isUnsigned_q ? {24'h000000, laneByte}
                                 : {{24{laneByte[7]}}, laneByte};
        case (lane_q)
          2'd0:    mergedWord[7:0]   = storeData_q[7:0];
          2'd1:    mergedWord[15:8]  = storeData_q[7:0];
          2'd2:    mergedWord[23:16] = storeData_q[7:0];
          default: mergedWord[31:24] = storeData_q[7:0];
        endcase
      end
      2'b01: begin
        loadValue = isUnsigned_q ? {16'h0000, laneHalf}
                                 : {{16{laneHalf[15]}}, laneHalf};
        if (lane_q[1]) begin
          mergedWord[31:16] = storeData_q;
        end else begin
          mergedWord[15:0] = storeData_q;
        end
      end
      default: begin
        loadValue  = mem_rd;
        mergedWord = mem_rd;
      end
    endcase
  end

  // Sequencing of one memory operation; strobes and pulses default low so
  // each lasts exactly one cycle, while addresses and data hold their value.
  always_comb begin
    state_d      = state_q;
    isStore_d    = isStore_q;
    size_d       = size_q;
    isUnsigned_d = isUnsigned_q;
    lane_d       = lane_q;
    storeData_d  = storeData_q;
    rd_d         = rd_q;
    memWe_d      = 1'b0;
    memRe_d      = 1'b0;
    memA_d       = memA_q;
    memWd_d      = memWd_q;
    wbValid_d    = 1'b0;
    wbData_d     = wbData_q;
    wbRd_d       = wbRd_q;
    fault_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          isStore_d    = req_we;
          size_d       = req_size;
          isUnsigned_d = req_unsigned;
          lane_d       = req_addr[1:0];
          storeData_d  = req_wdata[15:0];
          rd_d         = req_rd;
          if (reqFault) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else if (!req_we || !reqIsWord) begin
            memRe_d = 1'b1;
            memA_d  = {2'b00, req_addr[31:2]};
            state_d = RD_ISSUE;
          end else begin
            memWe_d = 1'b1;
            memA_d  = {2'b00, req_addr[31:2]};
            memWd_d = req_wdata;
            state_d = WR_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (!isStore_q) begin
          wbValid_d = 1'b1;
          wbData_d  = loadValue;
          wbRd_d    = rd_q;
          state_d   = IDLE;
        end else begin
          memWd_d = mergedWord;
          memWe_d = 1'b1;
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        state_d = IDLE;
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      isStore_q    <= 1'b0;
      size_q       <= 2'b00;
      isUnsigned_q <= 1'b0;
      lane_q       <= 2'b00;
      storeData_q  <= 16'h0000;
      rd_q         <= 5'd0;
      memWe_q      <= 1'b0;
      memRe_q      <= 1'b0;
      memA_q       <= 32'h0;
      memWd_q      <= 32'h0;
      wbValid_q    <= 1'b0;
      wbData_q     <= 32'h0;
      wbRd_q       <= 5'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      isStore_q    <= isStore_d;
      size_q       <= size_d;
      isUnsigned_q <= isUnsigned_d;
      lane_q       <= lane_d;
      storeData_q  <= storeData_d;
      rd_q         <= rd_d;
      memWe_q      <= memWe_d;
      memRe_q      <= memRe_d;
      memA_q       <= memA_d;
      memWd_q      <= memWd_d;
      wbValid_q    <= wbValid_d;
      wbData_q     <= wbData_d;
      wbRd_q       <= wbRd_d;
      fault_q      <= fault_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vector table, randomized operations against a
// byte-lane reference model, and a reset-during-store sequence.
module tb_lsu_mem_stage;

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        fault;

  logic [31:0] memArr [0:63];
  logic [31:0] modelMem [0:63];

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        expFault;
    logic [31:0] expData;
    logic [31:0] expMem;
  } vec_t;

  vec_t vecs [0:16];

  lsu_mem_stage #(.MEM_WORDS(42)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall), .mem_we(mem_we), .mem_re(mem_re),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: read data valid one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) memArr[mem_a[5:0]] <= mem_wd;
    if (mem_re) mem_rd <= memArr[mem_a[5:0]];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end else begin
      passes++;
    end
  endtask

  // Reference: compute fault, load result and resulting memory word from
  // the lane rules with plain arithmetic.
  function automatic void refModel(input logic we, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata,
                                   output logic expFault, output logic [31:0] expData,
                                   output logic [31:0] expMem);
    logic [31:0] w, lane, mask, wd;
    int k;
    w = modelMem[addr[7:2]];
    expFault = (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0) ||
               (RANGE_EN && addr[31:2] >= 30'd42);
    if (size == 2'd0) begin
      k = int'(addr[1:0]);
      lane = (w >> (8 * k)) % 256;
      if (!uns && lane >= 128) lane = lane - 256;
      mask = 32'd255 << (8 * k);
      wd = (wdata % 256) << (8 * k);
    end else if (size == 2'd1) begin
      k = addr[1] ? 2 : 0;
      lane = (w >> (8 * k)) % 65536;
      if (!uns && lane >= 32768) lane = lane - 65536;
      mask = 32'd65535 << (8 * k);
      wd = (wdata % 65536) << (8 * k);
    end else begin
      lane = w;
      mask = 32'hFFFF_FFFF;
      wd = wdata;
    end
    expData = lane;
    expMem = we ? ((w & ~mask) | wd) : w;
  endfunction

  // Present one op in cycle T, then check every cycle until the unit idles.
  // With junk set, unrelated requests are driven while stall is expected.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic expFault,
                               input logic [31:0] expData, input logic [31:0] expMem,
                               input logic junk);
    int done;
    logic isSub, isWordSt;
    isWordSt = we && size[1];
    isSub = we && !size[1];
    if (expFault) done = 2;
    else if (!we) done = 3;
    else if (isWordSt) done = 2;
    else done = 4;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    checkOutput("stall_T", {31'd0, stall}, 32'd0);
    for (int c = 1; c <= done; c++) begin
      @(posedge clk); #1;
      if (junk && c < done) begin
        req_valid = 1'b1; req_we = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom_range(0, 31));
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("stall_c%0d", c), {31'd0, stall}, {31'd0, c < done});
      checkOutput($sformatf("mem_re_c%0d", c), {31'd0, mem_re},
                  {31'd0, !expFault && (!we || isSub) && c == 1});
      checkOutput($sformatf("mem_we_c%0d", c), {31'd0, mem_we},
                  {31'd0, !expFault && ((isWordSt && c == 1) || (isSub && c == 3))});
      checkOutput($sformatf("fault_c%0d", c), {31'd0, fault}, {31'd0, expFault && c == 1});
      checkOutput($sformatf("wb_valid_c%0d", c), {31'd0, wb_valid},
                  {31'd0, !expFault && !we && c == 3});
      if (mem_re || mem_we) checkOutput("mem_a", mem_a, {2'b00, addr[31:2]});
      if (mem_we) checkOutput("mem_wd", mem_wd, expMem);
      if (!expFault && !we && c == 3) begin
        checkOutput("wb_data", wb_data, expData);
        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      end
    end
    if (we && !expFault) checkOutput("mem_word", memArr[addr[7:2]], expMem);
    if (expFault) checkOutput("mem_untouched", memArr[addr[7:2]], modelMem[addr[7:2]]);
  endtask

  initial begin
    logic        rWe, rUns, rFault;
    logic [1:0]  rSize;
    logic [31:0] rAddr, rWdata, rData, rMem;
    logic [4:0]  rRd;

    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        5'd7,  1'b0, 32'h8000_00F4, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        5'd3,  1'b0, 32'hFFFF_FF80, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        5'd4,  1'b0, 32'h0000_0080, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        5'd5,  1'b0, 32'h0000_00F4, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        5'd6,  1'b0, 32'hFFFF_8000, 32'h0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        5'd8,  1'b0, 32'h0000_8000, 32'h0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h15, 32'h1234_56AB, 5'd0, 1'b0, 32'h0,         32'h0000_AB05};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        5'd10, 1'b0, 32'h0000_AB05, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h06, 32'h1111_1111, 5'd0, 1'b1, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        5'd9,  1'b1, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h1234_ABCD, 5'd0, 1'b0, 32'h0,         32'hABCD_AB05};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h18, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h0,         32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h18, 32'h0,        5'd31, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'hA8, 32'h0,        5'd2,  RANGE_EN, 32'h2A2A_2A2A, 32'h0};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        5'd11, 1'b0, 32'hFFFF_FFF4, 32'h0};
    vecs[15] = '{1'b0, 2'd3, 1'b0, 32'h14, 32'h0,        5'd12, 1'b0, 32'hABCD_AB05, 32'h0};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 32'h1F, 32'hFFFF_FF99, 5'd0, 1'b0, 32'h0,         32'h9977_7777};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    for (int i = 0; i < 64; i++) begin
      memArr[i] <= 32'h0101_0101 * 32'(i);
      modelMem[i] = 32'h0101_0101 * 32'(i);
    end
    memArr[4] <= 32'h8000_00F4;  modelMem[4] = 32'h8000_00F4;
    memArr[5] <= 32'h0000_0005;  modelMem[5] = 32'h0000_0005;
    memArr[6] <= 32'h6666_6666;  modelMem[6] = 32'h6666_6666;
    memArr[7] <= 32'h7777_7777;  modelMem[7] = 32'h7777_7777;
    memArr[42] <= 32'h2A2A_2A2A; modelMem[42] = 32'h2A2A_2A2A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_re", {31'd0, mem_re}, 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_mem_wd", mem_wd, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rd, vecs[i].expFault, vecs[i].expData, vecs[i].expMem,
                    1'(i % 2));
      if (vecs[i].we && !vecs[i].expFault) modelMem[vecs[i].addr[7:2]] = vecs[i].expMem;
    end

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      rWe = 1'($urandom_range(0, 1));
      rSize = 2'($urandom_range(0, 3));
      rUns = 1'($urandom_range(0, 1));
      rAddr = 32'($urandom_range(0, 40)) * 4 + 32'($urandom_range(0, 3));
      rWdata = $urandom;
      rRd = 5'($urandom_range(0, 31));
      refModel(rWe, rSize, rUns, rAddr, rWdata, rFault, rData, rMem);
      applyStimulus(rWe, rSize, rUns, rAddr, rWdata, rRd, rFault, rData, rMem,
                    1'($urandom_range(0, 1)));
      if (rWe && !rFault) modelMem[rAddr[7:2]] = rMem;
    end

    $display("[TB] reset during sub-word store");
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h1C; req_wdata = 32'h0000_5A5A; req_rd = 5'd0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_seq_re", {31'd0, mem_re}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h1C; req_rd = 5'd9;
    @(negedge clk);
    checkOutput("rst_seq_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_seq_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_seq_re0", {31'd0, mem_re}, 32'd0);
    checkOutput("rst_seq_a", mem_a, 32'd0);
    checkOutput("rst_seq_wd", mem_wd, 32'd0);
    checkOutput("rst_seq_wbv", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_seq_wbd", wb_data, 32'd0);
    checkOutput("rst_seq_wbrd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_seq_fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_seq_new_re", {31'd0, mem_re}, 32'd1);
    checkOutput("rst_seq_new_a", mem_a, 32'd7);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_seq_new_wbv", {31'd0, wb_valid}, 32'd1);
    checkOutput("rst_seq_new_wbd", wb_data, modelMem[7]);
    checkOutput("rst_seq_mem", memArr[7], modelMem[7]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the MEM stage of the pipelined MIPS core, between the EX/MEM pipeline register and the word-addressed data memory. Converts byte addresses to word indices, performs byte/halfword/word loads with sign or zero extension, and implements sub-word stores as read-modify-write. All memory strobes are registered and glitch-free, because the data memory is edge-sensitive on its strobes. A stall output holds the upstream pipeline while an access is in flight.

## Interface
- MEM_WORDS, 42, data memory depth in 32-bit words (range check only)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  memory op presented by EX/MEM
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- req_unsigned  in  1  zero-extend loads (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination register
- stall  out  1  unit busy; upstream holds the request
- mem_we  out  1  data memory write strobe, registered
- mem_re  out  1  data memory read strobe, registered
- mem_a  out  32  word index = {2'b00, addr[31:2]}, registered
- mem_wd  out  32  write data, registered
- mem_rd  in  32  read data; valid one cycle after mem_re
- wb_valid  out  1  one-cycle pulse: load result ready
- wb_data  out  32  extended load data
- wb_rd  out  5  destination register of the load
- fault  out  1  one-cycle pulse: misaligned (or out-of-range) access dropped

## Operation
- Acceptance: req_valid && !stall. stall = (state != IDLE), combinational from the state register.
- States and transitions:
  - IDLE:
    - Accepted op latches size, unsigned, addr[1:0], wdata, rd.
    - Fault → FAULT.
    - Load or sub-word store → RD_ISSUE.
    - Word store → WR_ISSUE, with mem_wd = req_wdata.
  - RD_ISSUE: mem_re = 1 → RD_WAIT.
  - RD_WAIT: mem_rd valid.
    - Load: register the extracted value, wb_valid = 1 next cycle → IDLE.
    - Sub-word store: mem_wd = merged word → WR_ISSUE.
  - WR_ISSUE: mem_we = 1 → IDLE.
  - FAULT: fault = 1 → IDLE.
- Little-endian lanes:
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword h = addr[1] occupies bits [16h+15:16h].
- Load extraction: the selected lane is shifted to bit 0, then sign- or zero-extended per req_unsigned.
- Sub-word store merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]; the other bytes keep mem_rd.
- Misalignment, which raises a fault with no memory access:
  - half with addr[0] = 1
  - word with addr[1:0] != 0
- mem_re and mem_we are never high in the same cycle. mem_a is held constant from RD_ISSUE/WR_ISSUE until return to IDLE.
- Stores never raise wb_valid.

## Timing
- Reset (synchronous): state = IDLE and all outputs 0: stall, mem_we, mem_re, mem_a, mem_wd, wb_valid, wb_data, wb_rd, fault.
- Load accepted in cycle T:
  - mem_re high in T+1.
  - mem_rd sampled in T+2.
  - wb_valid/wb_data/wb_rd in T+3.
  - Next accept possible in T+3.
- Word store accepted in T: mem_we high in T+1; next accept in T+2.
- Sub-word store accepted in T:
  - mem_re high in T+1.
  - merge in T+2.
  - mem_we high in T+3.
  - next accept in T+4.
- Fault accepted in T: fault high in T+1; next accept in T+2.
- stall is high from T+1 until the cycle before the next accept.
- A request presented while stall = 1 is ignored and must be held by upstream.
- Reset mid-operation abandons the op:
  - A sub-word store reset before WR_ISSUE leaves memory unmodified.
  - No wb_valid or fault pulse is emitted afterwards.

## Configuration
- LSU_RANGE_CHECK_EN defined:
  - An op whose word index addr[31:2] >= MEM_WORDS takes the FAULT path.
  - No strobe is issued for that op.
- Undefined:
  - No range check; the index passes through unmodified.
  - MEM_WORDS is unused.

## Test plan
- Reset, then lw addr 0x10 with memory word 4 = 0x8000_00F4 → mem_re at T+1, mem_a = 4; at T+3 wb_valid = 1, wb_data = 0x8000_00F4, wb_rd echoed; stall high T+1..T+2.
- lb and lbu at 0x13 with word 4 = 0x8000_00F4 → wb_data 0xFFFF_FF80 and 0x0000_0080. lh at 0x10 → 0x0000_00F4.
- sb wdata 0xAB at addr 0x15, word 5 = 0x0000_0005 → mem_re T+1, mem_we T+3 with mem_wd = 0x0000_AB05; a following lw of 0x14 returns 0x0000_AB05.
- sw addr 0x06 and lh addr 0x03 → fault pulse at T+1; mem_we and mem_re stay 0; stall high only in T+1.
- With LSU_RANGE_CHECK_EN and MEM_WORDS = 42, lw at 0xA8 (index 42) → fault at T+1, no strobe. Without the macro → mem_re with mem_a = 42.
- Assert reset in T+2 of an sh → memory unchanged, all outputs 0 in the following cycle; a new request is accepted immediately after reset deasserts.
